// File: rtl/array_mult_4bit.sv
// Unsigned 4x4 -> 8-bit array multiplier: AND partial products reduced by three
// ripple rows of half/full adders, captured in an output register with a valid flag.

module array_mult_4bit_ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module array_mult_4bit_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module array_mult_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p,
  output logic       out_valid
);

  // pp[i][j] = a[j] & b[i]: row i is the multiplicand gated by multiplier bit i.
  logic [3:0][3:0] pp;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = a[j] & b[i];
      end
    end
  end

  logic [3:0] s1, c1;
  logic [3:0] s2, c2;
  logic [3:0] s3, c3;

  // Row 1: pp[0][3:1] + pp[1][3:0]; the top bit has no pp[0] term, hence a half adder.
  array_mult_4bit_ha u_r1_0 (.a_i(pp[0][1]), .b_i(pp[1][0]),              .s_o(s1[0]), .c_o(c1[0]));
  array_mult_4bit_fa u_r1_1 (.a_i(pp[0][2]), .b_i(pp[1][1]), .c_i(c1[0]), .s_o(s1[1]), .c_o(c1[1]));
  array_mult_4bit_fa u_r1_2 (.a_i(pp[0][3]), .b_i(pp[1][2]), .c_i(c1[1]), .s_o(s1[2]), .c_o(c1[2]));
  array_mult_4bit_ha u_r1_3 (.a_i(pp[1][3]), .b_i(c1[2]),                 .s_o(s1[3]), .c_o(c1[3]));

  // Row 2: previous row shifted down one bit, its carry-out entering at the top.
  array_mult_4bit_ha u_r2_0 (.a_i(s1[1]), .b_i(pp[2][0]),              .s_o(s2[0]), .c_o(c2[0]));
  array_mult_4bit_fa u_r2_1 (.a_i(s1[2]), .b_i(pp[2][1]), .c_i(c2[0]), .s_o(s2[1]), .c_o(c2[1]));
  array_mult_4bit_fa u_r2_2 (.a_i(s1[3]), .b_i(pp[2][2]), .c_i(c2[1]), .s_o(s2[2]), .c_o(c2[2]));
  array_mult_4bit_fa u_r2_3 (.a_i(c1[3]), .b_i(pp[2][3]), .c_i(c2[2]), .s_o(s2[3]), .c_o(c2[3]));

  array_mult_4bit_ha u_r3_0 (.a_i(s2[1]), .b_i(pp[3][0]),              .s_o(s3[0]), .c_o(c3[0]));
  array_mult_4bit_fa u_r3_1 (.a_i(s2[2]), .b_i(pp[3][1]), .c_i(c3[0]), .s_o(s3[1]), .c_o(c3[1]));
  array_mult_4bit_fa u_r3_2 (.a_i(s2[3]), .b_i(pp[3][2]), .c_i(c3[1]), .s_o(s3[2]), .c_o(c3[2]));
  array_mult_4bit_fa u_r3_3 (.a_i(c2[3]), .b_i(pp[3][3]), .c_i(c3[2]), .s_o(s3[3]), .c_o(c3[3]));

  logic [7:0] p_d, p_q;
  logic       out_valid_d, out_valid_q;

  always_comb begin
    p_d         = p_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      p_d = {c3[3], s3, s2[0], s1[0], pp[0][0]};
    end
  end

  // Output register: operands are only sampled with in_valid, otherwise p holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_mult_4bit.sv
// Scoreboard bench for array_mult_4bit: products queued at drive time, popped on output.

module tb_array_mult_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] p;
  logic       out_valid;

  int n_checks;
  int n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] exp_p;

  array_mult_4bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .p        (p),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t required completion", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    int r;
    r = int'(x) * int'(y);
    return r[7:0];
  endfunction

  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    in_valid = v;
    a = x;
    b = y;
    if (v) exp_q.push_back(ref_mul(x, y));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 4'd9;
    b = 4'd9;
    #1;
    n_checks++;
    if (p !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: p=%h out_valid=%b, required p=00 out_valid=0", p, out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (p !== 8'h00 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: p=%h out_valid=%b, required p=00 out_valid=0", i, p, out_valid);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (p !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: p=%h out_valid=%b, required p=00 out_valid=0", p, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [3:0] va[5] = '{4'd0, 4'd2, 4'd3, 4'd7, 4'd15};
    logic [3:0] vb[5] = '{4'd0, 4'd0, 4'd5, 4'd9, 4'd15};
    logic [7:0] vp[5] = '{8'd0, 8'd0, 8'd15, 8'd63, 8'd225};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, va[i], vb[i]);
      @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL directed[%0d]: scoreboard empty, p=%h", i, p);
      end else begin
        exp_p = exp_q.pop_front();
        if (p !== exp_p || p !== vp[i] || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL directed[%0d]: %0d*%0d p=%0d out_valid=%b, required p=%0d out_valid=1",
                   i, va[i], vb[i], p, out_valid, vp[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd3, 4'd5);
    @(posedge clk);
    #1;
    exp_p = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (p !== exp_p || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_capture: p=%0d out_valid=%b, required p=15 out_valid=1", p, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd15, 4'd15);
      @(posedge clk);
      #1;
      n_checks++;
      if (p !== 8'd15 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: p=%0d out_valid=%b, required p=15 out_valid=0", i, p, out_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'd15, 4'd15);
    @(posedge clk);
    #1;
    exp_p = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (p !== exp_p || p !== 8'hE1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: p=%h out_valid=%b, required p=e1 out_valid=1", p, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (p !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: p=%h out_valid=%b, required p=00 out_valid=0", p, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'd9;
    b = 4'd9;
    @(posedge clk);
    #1;
    n_checks++;
    if (p !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_discard: p=%h out_valid=%b, required p=00 out_valid=0", p, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, i[3:0], i[7:4]);
      @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        errs++;
        $display("FAIL exhaustive[%0d]: scoreboard empty, p=%h", i, p);
      end else begin
        exp_p = exp_q.pop_front();
        if (p !== exp_p || out_valid !== 1'b1) begin
          n_fail++;
          errs++;
          if (errs < 10)
            $display("FAIL exhaustive: %0d*%0d p=%0d out_valid=%b, required p=%0d out_valid=1",
                     i[3:0], i[7:4], p, out_valid, exp_p);
        end
      end
    end
  endtask

  task automatic test_identity_zero();
    for (int bv = 1; bv >= 0; bv--) begin
      for (int i = 0; i < 16; i++) begin
        drive(1'b1, i[3:0], bv[3:0]);
        @(posedge clk);
        #1;
        exp_p = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (p !== exp_p || p !== ((bv == 1) ? 8'(i) : 8'd0) || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL identity_zero: %0d*%0d p=%0d out_valid=%b, required p=%0d out_valid=1",
                   i, bv, p, out_valid, (bv == 1) ? i : 0);
        end
      end
    end
    drive(1'b1, 4'd1, 4'd11);
    @(posedge clk);
    #1;
    exp_p = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (p !== exp_p || p !== 8'd11 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL identity_left: p=%0d out_valid=%b, required p=11 out_valid=1", p, out_valid);
    end
    drive(1'b0, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || p !== 8'd11) begin
      n_fail++;
      $display("FAIL idle_after: p=%0d out_valid=%b, required p=11 out_valid=0", p, out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = 4'd0;
    b = 4'd0;
    test_reset();
    test_directed();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_identity_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
